// File: rtl/tx_line_buf.sv
// rtl/tx_line_buf.sv - transmit line buffer between the cipher byte stream and the UART
// Collects bytes while idle, then drains them over valid/ready with an optional CR/LF.
module tx_line_buf #(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              print_buf,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic [ADDR_W:0]   buf_count,
  output logic              buf_empty,
  output logic              buf_full,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_SEND_CR = 2'd2,
    ST_SEND_LF = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);
  localparam logic [7:0]      CR_C    = 8'h0D;
  localparam logic [7:0]      LF_C    = 8'h0A;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                mem_we;
  logic [7:0]          mem_q [DEPTH];
  logic                full;

  assign full = (count_q == DEPTH_C);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        // A same-cycle write lands first, so it alone is enough to start a drain.
        if (print_buf) begin
          if ((count_q != '0) || wr_en) begin
            state_d = ST_DRAIN;
          end else if (APPEND_CRLF) begin
            state_d = ST_SEND_CR;
          end
        end
      end

      ST_DRAIN: begin
        tx_valid = 1'b1;
        tx_data  = mem_q[rd_ptr_q];
        if (tx_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
          if (count_q == ONE_C) begin
            state_d = APPEND_CRLF ? ST_SEND_CR : ST_IDLE;
          end
        end
      end

      ST_SEND_CR: begin
        tx_valid = 1'b1;
        tx_data  = CR_C;
        if (tx_ready) begin
          state_d = ST_SEND_LF;
        end
      end

      ST_SEND_LF: begin
        tx_valid = 1'b1;
        tx_data  = LF_C;
        if (tx_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_q != ST_IDLE) && wr_en) begin
      ovf_d = 1'b1;
    end

    // Every completed line leaves the buffer empty and realigned at slot 0.
    if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign buf_count = count_q;
  assign buf_empty = (count_q == '0);
  assign buf_full  = full;
  assign busy      = (state_q != ST_IDLE);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_tx_line_buf.sv
// tb/tb_tx_line_buf.sv - directed self-checking bench for tx_line_buf
// Main instance uses CR/LF; a second instance without the terminator covers the empty print.
module tb_tx_line_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en, print_buf, tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [5:0] buf_count;
  logic       buf_empty, buf_full, busy, ovf;

  logic       wr_en_b, print_b;
  logic       tx_valid_b;
  logic [7:0] tx_data_b;
  logic [5:0] buf_count_b;
  logic       buf_empty_b, buf_full_b, busy_b, ovf_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_line_buf #(.DEPTH(32), .ADDR_W(5), .APPEND_CRLF(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .print_buf(print_buf),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .buf_count(buf_count),
    .buf_empty(buf_empty), .buf_full(buf_full), .busy(busy), .ovf(ovf)
  );

  tx_line_buf #(.DEPTH(32), .ADDR_W(5), .APPEND_CRLF(1'b0)) dut_b (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en_b), .print_buf(print_b),
    .tx_ready(tx_ready), .tx_valid(tx_valid_b), .tx_data(tx_data_b), .buf_count(buf_count_b),
    .buf_empty(buf_empty_b), .buf_full(buf_full_b), .busy(busy_b), .ovf(ovf_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wr_data = b;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic print();
    print_buf = 1'b1;
    step();
    print_buf = 1'b0;
  endtask

  // Expects a byte offered this cycle with tx_ready=1, then advances one cycle.
  task automatic chk_tx(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp});
    step();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, tx_valid}, 32'd0);
    chk({tag, "_data"}, {24'd0, tx_data}, 32'h00);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_count"}, {26'd0, buf_count}, 32'd0);
    chk({tag, "_empty"}, {31'd0, buf_empty}, 32'd1);
    chk({tag, "_full"}, {31'd0, buf_full}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] hi [4];
    rst = 1'b1; wr_data = 8'h00; wr_en = 1'b0; print_buf = 1'b0; tx_ready = 1'b0;
    wr_en_b = 1'b0; print_b = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk_idle("rst");
    chk("rst_ovf", {31'd0, ovf}, 32'd0);

    // Two bytes, full-rate drain
    wr(8'h41);
    wr(8'h42);
    chk("t1_count", {26'd0, buf_count}, 32'd2);
    tx_ready = 1'b1;
    print();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk_tx("t1_b0", 8'h41);
    chk_tx("t1_b1", 8'h42);
    chk_tx("t1_cr", 8'h0D);
    chk_tx("t1_lf", 8'h0A);
    chk_idle("t1_end");

    // Stalled then toggled tx_ready
    wr(8'h48);
    wr(8'h49);
    tx_ready = 1'b0;
    print();
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", {31'd0, tx_valid}, 32'd1);
      chk("t2_stall_data", {24'd0, tx_data}, 32'h48);
      step();
    end
    hi[0] = 8'h48; hi[1] = 8'h49; hi[2] = 8'h0D; hi[3] = 8'h0A;
    for (int i = 0; i < 4; i++) begin
      tx_ready = 1'b1;
      chk_tx("t2_xfer", hi[i]);
      tx_ready = 1'b0;
      if (i < 3) begin
        chk("t2_hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("t2_hold_data", {24'd0, tx_data}, {24'd0, hi[i+1]});
        step();
      end
    end
    chk_idle("t2_end");

    // Fill, overflow, drain
    for (int i = 0; i < 32; i++) wr(8'(i));
    chk("t3_full", {31'd0, buf_full}, 32'd1);
    chk("t3_count32", {26'd0, buf_count}, 32'd32);
    chk("t3_ovf_pre", {31'd0, ovf}, 32'd0);
    wr(8'h20);
    chk("t3_ovf", {31'd0, ovf}, 32'd1);
    chk("t3_count_hold", {26'd0, buf_count}, 32'd32);
    tx_ready = 1'b1;
    print();
    for (int i = 0; i < 32; i++) chk_tx("t3_byte", 8'(i));
    chk_tx("t3_cr", 8'h0D);
    chk_tx("t3_lf", 8'h0A);
    chk_idle("t3_end");
    chk("t3_ovf_sticky", {31'd0, ovf}, 32'd1);

    // Empty print, both terminator settings
    print_b = 1'b1;
    print();
    print_b = 1'b0;
    chk("t4b_valid", {31'd0, tx_valid_b}, 32'd0);
    chk("t4b_busy", {31'd0, busy_b}, 32'd0);
    chk_tx("t4_cr", 8'h0D);
    chk("t4b_valid2", {31'd0, tx_valid_b}, 32'd0);
    chk_tx("t4_lf", 8'h0A);
    chk_idle("t4_end");

    // Same-cycle write+print, write during drain dropped
    do_reset();
    chk("t5_ovf_clr", {31'd0, ovf}, 32'd0);
    wr_data = 8'h5A;
    wr_en = 1'b1;
    print();
    wr_en = 1'b0;
    wr_data = 8'h33;
    wr_en = 1'b1;
    chk_tx("t5_b0", 8'h5A);
    wr_en = 1'b0;
    chk("t5_ovf", {31'd0, ovf}, 32'd1);
    chk_tx("t5_cr", 8'h0D);
    chk_tx("t5_lf", 8'h0A);
    chk_idle("t5_end");

    // Reset mid-drain
    do_reset();
    wr(8'h61);
    wr(8'h62);
    wr(8'h63);
    print();
    chk_tx("t6_b0", 8'h61);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("t6_rst");
    chk("t6_ovf", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t6_quiet", {31'd0, tx_valid}, 32'd0);
      step();
    end
    wr(8'h31);
    print();
    chk_tx("t6_b", 8'h31);
    chk_tx("t6_cr", 8'h0D);
    chk_tx("t6_lf", 8'h0A);
    chk_idle("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_line_buf.md
Name: tx_line_buf

Overview:
- Line buffer on the transmit side of the lab datapath.
- Collects the byte stream produced by the cipher block (tx data + data-ready strobe).
- On a print request, drains the stored bytes in order to the UART transmitter over a valid/ready handshake, followed by an optional CR/LF terminator.
- Sits between the lab top's tx outputs (tx data, tx data ready, print-buffer strobe) and the UART transmitter.

Parameters:
- DEPTH, 32, number of byte slots; power of two, minimum 2.
- ADDR_W, 5, log2(DEPTH).
- APPEND_CRLF, 1, when 1, append 0x0D then 0x0A after the drained bytes; when 0, send no terminator.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- wr_data  input  8  byte to store.
- wr_en  input  1  single-cycle write strobe for wr_data.
- print_buf  input  1  single-cycle request to drain the buffer.
- tx_ready  input  1  UART transmitter can accept a byte this cycle.
- tx_valid  output  1  tx_data is valid.
- tx_data  output  8  byte offered to the UART.
- buf_count  output  ADDR_W+1  bytes currently stored.
- buf_empty  output  1  buf_count==0.
- buf_full  output  1  buf_count==DEPTH.
- busy  output  1  high while not in IDLE.
- ovf  output  1  sticky: at least one write was dropped.

Behaviour:
- Reset: state=IDLE, write ptr=0, read ptr=0, buf_count=0, tx_valid=0, tx_data=0x00, busy=0, ovf=0, buf_empty=1, buf_full=0. Storage contents are don't-care.
- States: IDLE, DRAIN, SEND_CR, SEND_LF.
- A transfer occurs on any cycle with tx_valid && tx_ready.
- IDLE:
  - wr_en with buf_count<DEPTH: store at write ptr, increment ptr (wraps mod DEPTH) and buf_count.
  - wr_en with buf_full: byte dropped, ovf<=1, count unchanged.
  - print_buf: next state = DRAIN if buf_count>0; else SEND_CR if APPEND_CRLF; else stay IDLE with no output.
  - wr_en and print_buf in the same cycle: the byte is stored first and included in the drain (DRAIN entered even if count was 0).
- DRAIN:
  - tx_valid=1, tx_data=mem[read ptr]; both valid the cycle after print_buf.
  - On each transfer: read ptr++, buf_count--.
  - After the transfer of the last byte: go to SEND_CR if APPEND_CRLF, else IDLE.
  - Back-to-back transfers are allowed: one byte per cycle while tx_ready=1.
  - tx_valid and tx_data are held stable while tx_ready=0.
- SEND_CR: tx_valid=1, tx_data=0x0D; on transfer go to SEND_LF.
- SEND_LF: tx_valid=1, tx_data=0x0A; on transfer go to IDLE.
- On return to IDLE: write/read ptrs reset to 0, buf_count=0.
- Writes while busy: dropped, ovf<=1.
- print_buf while busy: ignored; not queued.
- Outside DRAIN/SEND_*: tx_valid=0, tx_data=0x00.
- ovf clears only on rst.
- rst asserted mid-drain: next cycle is the reset state; the partial line is discarded and no further tx_valid is asserted.
- buf_count, buf_empty and buf_full are registered-state derived and reflect updates the cycle after the write or transfer.

Test Plan:
- Reset, then write 0x41, 0x42, then print_buf with tx_ready=1 -> tx_valid for 4 consecutive cycles starting 1 cycle after print; tx_data=0x41,0x42,0x0D,0x0A; then busy=0, buf_count=0.
- Write "HI" (0x48, 0x49); print; hold tx_ready=0 for 5 cycles, then toggle it 1/0 -> tx_data stays 0x48 while stalled; sequence 0x48,0x49,0x0D,0x0A with exactly one transfer per tx_ready-high cycle; no byte lost or duplicated.
- Write 33 bytes 0x00..0x20 (DEPTH=32) -> buf_full=1 after 32 writes; 33rd byte dropped, ovf=1; print drains 0x00..0x1F then CR, LF; ovf stays 1.
- print_buf on an empty buffer -> output 0x0D, 0x0A only. With APPEND_CRLF=0 -> no tx_valid and busy stays 0.
- wr_en=1 (0x5A) and print_buf=1 in the same cycle on an empty buffer -> output 0x5A, 0x0D, 0x0A. A write of 0x33 during the drain -> dropped, ovf=1, not transmitted.
- Write 3 bytes, print, assert rst after the first transfer -> all outputs at reset values the next cycle, no further tx_valid; a subsequent write of 0x31 and print -> output 0x31, 0x0D, 0x0A.
